// File: rtl/voq_buf.sv
// Per-input-port virtual output queue buffer: four circular FIFOs, one per output port,
// drained by one-hot scheduler grants with a registered single-cycle pop response.
module voq_buf #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enq_valid,
    output logic              enq_ready,
    input  logic [1:0]        enq_dest,
    input  logic [DATA_W-1:0] enq_data,
    input  logic              sched_sel_en,
    input  logic [3:0]        sched_sel,
    output logic              deq_valid,
    output logic [1:0]        deq_dest,
    output logic [DATA_W-1:0] deq_data,
    output logic [3:0]        voq_empty,
    output logic [3:0]        voq_full,
    output logic              grant_err,
    input  logic              err_clr
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PtrOne = (AW + 1)'(1);

    logic [AW:0]       wr_ptr_q [4];
    logic [AW:0]       wr_ptr_d [4];
    logic [AW:0]       rd_ptr_q [4];
    logic [AW:0]       rd_ptr_d [4];
    logic [DATA_W-1:0] mem_q [4][DEPTH];

    logic              enq_fire;
    logic              sel_onehot;
    logic [1:0]        sel_idx;
    logic              grant_ok;
    logic              grant_bad;

    logic              deq_valid_q;
    logic [1:0]        deq_dest_q;
    logic [DATA_W-1:0] deq_data_q;
    logic              grant_err_q;
    logic              grant_err_d;

    // Extra pointer MSB distinguishes full from empty when index bits match.
    always_comb begin
        voq_empty = '0;
        voq_full  = '0;
        for (int k = 0; k < 4; k++) begin
            voq_empty[k] = (wr_ptr_q[k] == rd_ptr_q[k]);
            voq_full[k]  = (wr_ptr_q[k][AW-1:0] == rd_ptr_q[k][AW-1:0]) &&
                           (wr_ptr_q[k][AW] != rd_ptr_q[k][AW]);
        end
    end

    assign enq_ready = !voq_full[enq_dest];
    assign enq_fire  = enq_valid && enq_ready;

    always_comb begin
        sel_idx = '0;
        for (int k = 0; k < 4; k++) begin
            if (sched_sel[k]) sel_idx = 2'(k);
        end
    end

    assign sel_onehot = $onehot(sched_sel);
    assign grant_ok   = sched_sel_en && sel_onehot && !voq_empty[sel_idx];
    assign grant_bad  = sched_sel_en && !grant_ok;

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            wr_ptr_d[k] = wr_ptr_q[k];
            rd_ptr_d[k] = rd_ptr_q[k];
            if (enq_fire && (enq_dest == 2'(k))) wr_ptr_d[k] = wr_ptr_q[k] + PtrOne;
            if (grant_ok && (sel_idx == 2'(k)))  rd_ptr_d[k] = rd_ptr_q[k] + PtrOne;
        end
    end

    // A new error this cycle takes priority over a clear request.
    always_comb begin
        grant_err_d = grant_err_q;
        if (grant_bad) begin
            grant_err_d = 1'b1;
        end else if (err_clr) begin
            grant_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (enq_fire) mem_q[enq_dest][wr_ptr_q[enq_dest][AW-1:0]] <= enq_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                wr_ptr_q[k] <= '0;
                rd_ptr_q[k] <= '0;
            end
            deq_valid_q <= 1'b0;
            deq_dest_q  <= '0;
            deq_data_q  <= '0;
            grant_err_q <= 1'b0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                wr_ptr_q[k] <= wr_ptr_d[k];
                rd_ptr_q[k] <= rd_ptr_d[k];
            end
            deq_valid_q <= grant_ok;
            if (grant_ok) begin
                deq_dest_q <= sel_idx;
                deq_data_q <= mem_q[sel_idx][rd_ptr_q[sel_idx][AW-1:0]];
            end
            grant_err_q <= grant_err_d;
        end
    end

    assign deq_valid = deq_valid_q;
    assign deq_dest  = deq_dest_q;
    assign deq_data  = deq_data_q;
    assign grant_err = grant_err_q;

endmodule

// File: tb/tb_voq_buf.sv
// Bench for voq_buf: directed scenarios plus random traffic, checked against a
// queue-based reference model of the four VOQs.
module tb_voq_buf;

    localparam int unsigned DEPTH  = 16;
    localparam int unsigned DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              enq_valid = 1'b0;
    logic              enq_ready;
    logic [1:0]        enq_dest = '0;
    logic [DATA_W-1:0] enq_data = '0;
    logic              sched_sel_en = 1'b0;
    logic [3:0]        sched_sel = '0;
    logic              deq_valid;
    logic [1:0]        deq_dest;
    logic [DATA_W-1:0] deq_data;
    logic [3:0]        voq_empty;
    logic [3:0]        voq_full;
    logic              grant_err;
    logic              err_clr = 1'b0;

    voq_buf #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enq_valid   (enq_valid),
        .enq_ready   (enq_ready),
        .enq_dest    (enq_dest),
        .enq_data    (enq_data),
        .sched_sel_en(sched_sel_en),
        .sched_sel   (sched_sel),
        .deq_valid   (deq_valid),
        .deq_dest    (deq_dest),
        .deq_data    (deq_data),
        .voq_empty   (voq_empty),
        .voq_full    (voq_full),
        .grant_err   (grant_err),
        .err_clr     (err_clr)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: one queue of descriptors per destination.
    logic [DATA_W-1:0] mq [4][$];
    logic              exp_dv;
    logic [1:0]        exp_dd;
    logic [DATA_W-1:0] exp_data;
    logic              exp_err;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 4; k++) mq[k].delete();
        exp_dv   = 1'b0;
        exp_dd   = '0;
        exp_data = '0;
        exp_err  = 1'b0;
    endtask

    // One clock cycle: drive inputs, check pre-edge flags, advance model, check post-edge.
    task automatic step(input logic ev, input logic [1:0] ed, input logic [DATA_W-1:0] edata,
                        input logic se, input logic [3:0] ss, input logic ec);
        logic [3:0] e_empty;
        logic [3:0] e_full;
        logic       acc;
        logic       legal;
        int         idx;
        enq_valid    = ev;
        enq_dest     = ed;
        enq_data     = edata;
        sched_sel_en = se;
        sched_sel    = ss;
        err_clr      = ec;
        #1;
        for (int k = 0; k < 4; k++) begin
            e_empty[k] = (mq[k].size() == 0);
            e_full[k]  = (mq[k].size() == DEPTH);
        end
        chk("voq_empty", 64'(voq_empty), 64'(e_empty));
        chk("voq_full", 64'(voq_full), 64'(e_full));
        chk("enq_ready", 64'(enq_ready), 64'(!e_full[ed]));
        acc = ev && !e_full[ed];
        idx = 0;
        for (int k = 0; k < 4; k++) if (ss[k]) idx = k;
        legal = se && ($countones(ss) == 1) && (mq[idx].size() != 0);
        exp_dv = legal;
        if (legal) begin
            exp_dd   = 2'(idx);
            exp_data = mq[idx].pop_front();
        end
        if (acc) mq[ed].push_back(edata);
        if (se && !legal) exp_err = 1'b1;
        else if (ec) exp_err = 1'b0;
        @(posedge clk);
        #1;
        chk("deq_valid", 64'(deq_valid), 64'(exp_dv));
        chk("deq_dest", 64'(deq_dest), 64'(exp_dd));
        chk("deq_data", 64'(deq_data), 64'(exp_data));
        chk("grant_err", 64'(grant_err), 64'(exp_err));
    endtask

    task automatic idle();
        step(1'b0, 2'd0, '0, 1'b0, 4'b0000, 1'b0);
    endtask

    // Asserts reset away from a clock edge and checks outputs drop immediately.
    task automatic apply_reset();
        enq_valid    = 1'b0;
        sched_sel_en = 1'b0;
        sched_sel    = '0;
        err_clr      = 1'b0;
        rst_n        = 1'b0;
        #1;
        model_clear();
        chk("rst_deq_valid", 64'(deq_valid), 64'd0);
        chk("rst_deq_dest", 64'(deq_dest), 64'd0);
        chk("rst_deq_data", 64'(deq_data), 64'd0);
        chk("rst_voq_empty", 64'(voq_empty), 64'hf);
        chk("rst_voq_full", 64'(voq_full), 64'd0);
        chk("rst_grant_err", 64'(grant_err), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        #1;
        chk("rst_enq_ready", 64'(enq_ready), 64'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] ss;
        model_clear();
        apply_reset();
        idle();
        idle();

        // Three descriptors to dest 2, then three back-to-back grants.
        step(1'b1, 2'd2, 32'hA1, 1'b0, 4'b0000, 1'b0);
        step(1'b1, 2'd2, 32'hA2, 1'b0, 4'b0000, 1'b0);
        step(1'b1, 2'd2, 32'hA3, 1'b0, 4'b0000, 1'b0);
        step(1'b0, 2'd0, '0, 1'b1, 4'b0100, 1'b0);
        chk("a1_data", 64'(deq_data), 64'hA1);
        step(1'b0, 2'd0, '0, 1'b1, 4'b0100, 1'b0);
        step(1'b0, 2'd0, '0, 1'b1, 4'b0100, 1'b0);
        chk("a3_data", 64'(deq_data), 64'hA3);
        idle();

        // Fill dest 1, refuse the 17th, pop one, refill, then cross the pointer wrap.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 2'd1, 32'h1000 + 32'(i), 1'b0, 4'b0000, 1'b0);
        chk("full1", 64'(voq_full[1]), 64'd1);
        step(1'b1, 2'd1, 32'hDEAD, 1'b0, 4'b0000, 1'b0);
        step(1'b0, 2'd0, '0, 1'b0, 4'b0000, 1'b0);
        step(1'b0, 2'd1, '0, 1'b1, 4'b0010, 1'b0);
        chk("first_pop1", 64'(deq_data), 64'h1000);
        step(1'b1, 2'd1, 32'h2000, 1'b0, 4'b0000, 1'b0);
        for (int i = 0; i < 40; i++) step(1'b1, 2'd1, $urandom, 1'b1, 4'b0010, 1'b0);

        // Illegal grants: multi-hot, zero, empty queue; then clear.
        step(1'b0, 2'd0, '0, 1'b1, 4'b0011, 1'b0);
        step(1'b0, 2'd0, '0, 1'b1, 4'b0000, 1'b0);
        step(1'b0, 2'd0, '0, 1'b1, 4'b1000, 1'b0);
        step(1'b0, 2'd0, '0, 1'b0, 4'b1111, 1'b1);
        chk("err_cleared", 64'(grant_err), 64'd0);
        step(1'b0, 2'd0, '0, 1'b1, 4'b1000, 1'b1);
        step(1'b0, 2'd0, '0, 1'b0, 4'b0000, 1'b1);

        // Same-cycle enqueue and pop on a one-entry queue.
        step(1'b1, 2'd0, 32'hC0, 1'b0, 4'b0000, 1'b0);
        step(1'b1, 2'd0, 32'hB0, 1'b1, 4'b0001, 1'b0);
        chk("old_entry", 64'(deq_data), 64'hC0);
        step(1'b0, 2'd0, '0, 1'b1, 4'b0001, 1'b0);
        chk("then_b", 64'(deq_data), 64'hB0);
        // Enqueue to empty queue with grant to it: grant is illegal.
        step(1'b1, 2'd3, 32'hE3, 1'b1, 4'b1000, 1'b0);
        step(1'b0, 2'd0, '0, 1'b0, 4'b0000, 1'b1);

        // Random traffic, grants mostly one-hot.
        for (int i = 0; i < 300; i++) begin
            ss = 4'(1 << $urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) ss = 4'($urandom);
            step(1'($urandom_range(0, 3) != 0), 2'($urandom), $urandom,
                 1'($urandom_range(0, 1)), ss, 1'($urandom_range(0, 5) == 0));
        end

        // Mid-run reset with data held and a pop in flight.
        step(1'b1, 2'd3, 32'h33, 1'b0, 4'b0000, 1'b0);
        step(1'b1, 2'd3, 32'h34, 1'b0, 4'b0000, 1'b0);
        step(1'b0, 2'd0, '0, 1'b1, 4'b1000, 1'b0);
        chk("inflight_valid", 64'(deq_valid), 64'd1);
        #2;
        apply_reset();
        idle();
        chk("post_rst_empty", 64'(voq_empty), 64'hf);
        step(1'b0, 2'd0, '0, 1'b1, 4'b1000, 1'b0);
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
